// File: rtl/complex_dot_product_engine.sv
// complex_dot_product_engine: pipelined complex dot product, NI lanes per beat, BEATS beats per vector.
//   clk, reset (sync, active-high); start (IDLE only); in_valid/in_ready beat handshake;
//   a_in/b_in NI packed complex lanes (lane 0 in MSBs, real in upper half);
//   conj_mode (only with CDOT_CONJ_SELECT_EN: 1 = a*conj(b), 0 = a*b; otherwise always a*conj(b));
//   result/result_valid held in DONE until result_ready; busy outside IDLE.
module complex_dot_product_engine #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int NI = 8,
    parameter int NOE = 8,
    parameter int MULT_LAT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ELEMENT_WIDTH*NI-1:0] a_in,
    input  logic [ELEMENT_WIDTH*NI-1:0] b_in,
`ifdef CDOT_CONJ_SELECT_EN
    input  logic                        conj_mode,
`endif
    output logic [ELEMENT_WIDTH-1:0]    result,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic                        busy
);
    localparam int H = ELEMENT_WIDTH / 2;
    localparam int L = $clog2(NI);
    localparam int BEATS = (NOE + NI - 1) / NI;
    localparam int LAST_N = NOE - (BEATS - 1) * NI;
    localparam int CW = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic [CW-1:0]            beat_q;
    logic [H-1:0]             acc_re_q, acc_im_q;
    logic                     acc_last_q, result_valid_q;
    logic [ELEMENT_WIDTH-1:0] result_q;
    logic                     accept, start_ok, last_beat, conj;

    assign accept       = in_valid && state_q == LOAD;
    assign start_ok     = start && state_q == IDLE;
    assign last_beat    = beat_q == LAST_BEAT;
    assign in_ready     = state_q == LOAD;
    assign busy         = state_q != IDLE;
    assign result       = result_q;
    assign result_valid = result_valid_q;

`ifdef CDOT_CONJ_SELECT_EN
    logic conj_q;
    always_ff @(posedge clk) begin
        if (reset) conj_q <= 1'b1;
        else if (start_ok) conj_q <= conj_mode;
    end
    assign conj = conj_q;
`else
    assign conj = 1'b1;
`endif

    // Lane products; components are only kept to H bits, so unsigned H-bit
    // multiplies give the same low bits as the signed full products.
    logic [H-1:0] pre_d [NI];
    logic [H-1:0] pim_d [NI];
    for (genvar i = 0; i < NI; i++) begin : lane
        localparam int T = ELEMENT_WIDTH * (NI - i) - 1;
        logic [H-1:0] ar, ai, br, bi;
        logic         on;
        assign ar = a_in[T -: H];
        assign ai = a_in[T-H -: H];
        assign br = b_in[T -: H];
        assign bi = b_in[T-H -: H];
        // Lanes past the vector end in the final beat contribute nothing.
        assign on = !last_beat || (i < LAST_N);
        assign pre_d[i] = !on ? '0 : conj ? ar * br + ai * bi : ar * br - ai * bi;
        assign pim_d[i] = !on ? '0 : conj ? ai * br - ar * bi : ai * br + ar * bi;
    end

    // Multiplier pipeline, MULT_LAT registered stages.
    logic [H-1:0]          mre_q [MULT_LAT][NI];
    logic [H-1:0]          mim_q [MULT_LAT][NI];
    logic [MULT_LAT-1:0]   mv_q, ml_q;
    always_ff @(posedge clk) begin
        mre_q[0] <= pre_d;
        mim_q[0] <= pim_d;
        for (int s = 1; s < MULT_LAT; s++) begin
            mre_q[s] <= mre_q[s-1];
            mim_q[s] <= mim_q[s-1];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mv_q <= '0;
            ml_q <= '0;
        end else begin
            mv_q <= (mv_q << 1) | MULT_LAT'(accept);
            ml_q <= (ml_q << 1) | MULT_LAT'(accept && last_beat);
        end
    end

    // Registered adder tree, one level per register stage.
    logic [L-1:0] tv_q, tl_q;
    for (genvar k = 0; k < L; k++) begin : lvl
        localparam int N = NI >> (k + 1);
        logic [H-1:0] re_q [N];
        logic [H-1:0] im_q [N];
        if (k == 0) begin : leaf
            always_ff @(posedge clk) begin
                for (int j = 0; j < N; j++) begin
                    re_q[j] <= mre_q[MULT_LAT-1][2*j] + mre_q[MULT_LAT-1][2*j+1];
                    im_q[j] <= mim_q[MULT_LAT-1][2*j] + mim_q[MULT_LAT-1][2*j+1];
                end
            end
        end else begin : inner
            always_ff @(posedge clk) begin
                for (int j = 0; j < N; j++) begin
                    re_q[j] <= lvl[k-1].re_q[2*j] + lvl[k-1].re_q[2*j+1];
                    im_q[j] <= lvl[k-1].im_q[2*j] + lvl[k-1].im_q[2*j+1];
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tv_q <= '0;
            tl_q <= '0;
        end else begin
            tv_q <= (tv_q << 1) | L'(mv_q[MULT_LAT-1]);
            tl_q <= (tl_q << 1) | L'(mv_q[MULT_LAT-1] && ml_q[MULT_LAT-1]);
        end
    end

    // Accumulator and control FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            acc_re_q       <= '0;
            acc_im_q       <= '0;
            acc_last_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            acc_last_q <= tv_q[L-1] && tl_q[L-1];
            if (tv_q[L-1]) begin
                acc_re_q <= acc_re_q + lvl[L-1].re_q[0];
                acc_im_q <= acc_im_q + lvl[L-1].im_q[0];
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= LOAD;
                    beat_q   <= '0;
                    acc_re_q <= '0;
                    acc_im_q <= '0;
                end
                LOAD: if (accept) begin
                    beat_q  <= beat_q + 1'b1;
                    state_q <= last_beat ? DRAIN : LOAD;
                end
                // acc_last_q marks the edge after the final beat was summed in.
                DRAIN: if (acc_last_q) begin
                    state_q        <= DONE;
                    result_q       <= {acc_re_q, acc_im_q};
                    result_valid_q <= 1'b1;
                end
                DONE: if (result_ready) begin
                    state_q        <= IDLE;
                    result_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_dot_product_engine.sv
// tb_complex_dot_product_engine: directed checks of the dot product engine with NOE=8 and NOE=6 instances.
module tb_complex_dot_product_engine;
    localparam int EW = 64;
    localparam int NI = 4;
    localparam logic [63:0] EA   = {32'd1, 32'd2};
    localparam logic [63:0] EB   = {32'd3, 32'd4};
    localparam logic [63:0] GARB = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] R88  = {32'd88, 32'd16};
    localparam logic [63:0] RN   = {32'hFFFF_FFD8, 32'd80};
    localparam logic [63:0] R66  = {32'd66, 32'd12};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start8 = 1'b0, start6 = 1'b0, in_valid = 1'b0, result_ready = 1'b0;
    logic [EW*NI-1:0] a_in = '0, b_in = '0;
    logic [EW-1:0] res8, res6;
    logic rv8, rv6, rdy8, rdy6, busy8, busy6;
    int n_vec = 0;
    int n_err = 0;
`ifdef CDOT_CONJ_SELECT_EN
    logic conj_mode = 1'b1;
`endif

    always #5 clk = ~clk;

    complex_dot_product_engine #(.ELEMENT_WIDTH(EW), .NI(NI), .NOE(8), .MULT_LAT(2)) u8 (
        .clk(clk), .reset(reset), .start(start8), .in_valid(in_valid), .in_ready(rdy8),
        .a_in(a_in), .b_in(b_in),
`ifdef CDOT_CONJ_SELECT_EN
        .conj_mode(conj_mode),
`endif
        .result(res8), .result_valid(rv8), .result_ready(result_ready), .busy(busy8));

    complex_dot_product_engine #(.ELEMENT_WIDTH(EW), .NI(NI), .NOE(6), .MULT_LAT(2)) u6 (
        .clk(clk), .reset(reset), .start(start6), .in_valid(in_valid), .in_ready(rdy6),
        .a_in(a_in), .b_in(b_in),
`ifdef CDOT_CONJ_SELECT_EN
        .conj_mode(conj_mode),
`endif
        .result(res6), .result_valid(rv6), .result_ready(result_ready), .busy(busy6));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start, feed two beats (optionally with a 2-cycle in_valid gap), check latency and result.
    task automatic run(input bit six, input bit gaps, input logic [63:0] exp, input string tag);
        if (six) start6 = 1'b1; else start8 = 1'b1;
        tick;
        start6 = 1'b0;
        start8 = 1'b0;
        check({tag, "_busy"}, six ? busy6 : busy8, 64'd1);
        for (int b = 0; b < 2; b++) begin
            if (gaps && b == 1) begin
                tick;
                tick;
            end
            a_in = {4{EA}};
            b_in = {4{EB}};
            if (six && b == 1) begin
                a_in[127:0] = {2{GARB}};
                b_in[127:0] = {2{GARB}};
            end
            in_valid = 1'b1;
            check({tag, "_rdy"}, six ? rdy6 : rdy8, 64'd1);
            tick;
            in_valid = 1'b0;
        end
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k >= 4) check({tag, "_lat"}, six ? rv6 : rv8, {63'd0, k == 5});
        end
        check({tag, "_res"}, six ? res6 : res8, exp);
    endtask

    task automatic drain(input bit six, input string tag);
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        check({tag, "_rvfall"}, six ? rv6 : rv8, 64'd0);
        check({tag, "_idle"}, six ? busy6 : busy8, 64'd0);
    endtask

    initial begin
        tick;
        tick;
        check("rst_rdy", {62'd0, rdy8, rdy6}, 64'd0);
        check("rst_rv", {62'd0, rv8, rv6}, 64'd0);
        check("rst_busy", {62'd0, busy8, busy6}, 64'd0);
        check("rst_res8", res8, 64'd0);
        check("rst_res6", res6, 64'd0);
        reset = 1'b0;
        a_in = {4{EA}};
        b_in = {4{EB}};
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            check("idle_rdy", rdy8, 64'd0);
            check("idle_busy", busy8, 64'd0);
        end
        in_valid = 1'b0;

        run(1'b0, 1'b0, R88, "conj8");
        drain(1'b0, "conj8");
`ifdef CDOT_CONJ_SELECT_EN
        conj_mode = 1'b0;
        run(1'b0, 1'b0, RN, "plain8");
        drain(1'b0, "plain8");
        conj_mode = 1'b1;
`endif
        run(1'b1, 1'b0, R66, "noe6");
        drain(1'b1, "noe6");
        run(1'b0, 1'b1, R88, "gap8");
        drain(1'b0, "gap8");

        run(1'b0, 1'b0, R88, "hold");
        for (int c = 0; c < 10; c++) begin
            start8 = (c == 3);
            tick;
            check("hold_res", res8, R88);
            check("hold_busy", busy8, 64'd1);
            check("hold_rv", rv8, 64'd1);
        end
        start8 = 1'b1;
        result_ready = 1'b1;
        tick;
        start8 = 1'b0;
        result_ready = 1'b0;
        check("hold_exit_busy", busy8, 64'd0);
        check("hold_exit_rv", rv8, 64'd0);
        tick;
        check("hold_nostart", {63'd0, busy8}, 64'd0);

        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        a_in = {4{EA}};
        b_in = {4{EB}};
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst_busy", busy8, 64'd0);
        check("midrst_rv", rv8, 64'd0);
        check("midrst_res", res8, 64'd0);
        run(1'b0, 1'b0, R88, "after_rst");
        drain(1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/complex_dot_product_engine.md
COMPLEX_DOT_PRODUCT_ENGINE -- requirements
Module: complex_dot_product_engine

Interface
REQ-001 Parameter ELEMENT_WIDTH, default 64, is the packed complex element width: real part in the upper half, imaginary part in the lower half, each half signed two's complement.
REQ-002 Parameter NI, default 8, is the number of lanes per beat; it SHALL be a power of two and at least 2.
REQ-003 Parameter NOE, default 8, is the number of elements per vector; it SHALL be at least 1.
REQ-004 Parameter MULT_LAT, default 2, is the registered latency of each lane multiplier; it SHALL be at least 1.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin a new dot product; sampled only in IDLE.
REQ-008 in_valid  input  1  a_in/b_in carry a beat.
REQ-009 in_ready  output  1  engine accepts a beat this cycle.
REQ-010 a_in  input  ELEMENT_WIDTH*NI  operand A lanes, lane 0 in the MSBs.
REQ-011 b_in  input  ELEMENT_WIDTH*NI  operand B lanes, conjugated operand, lane 0 in the MSBs.
REQ-012 conj_mode  input  1  1 = a*conj(b), 0 = a*b; present only with CDOT_CONJ_SELECT_EN.
REQ-013 result  output  ELEMENT_WIDTH  packed complex dot product.
REQ-014 result_valid  output  1  result is held valid.
REQ-015 result_ready  input  1  consumer takes the result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 BEATS = ceil(NOE/NI); in the final beat, lanes with index at or above NOE-(BEATS-1)*NI SHALL contribute zero regardless of input data.
REQ-018 The FSM states SHALL be IDLE, LOAD, DRAIN and DONE.
REQ-019 FSM transitions:
- IDLE->LOAD on start, which also clears the accumulator.
- LOAD->DRAIN on acceptance of beat BEATS.
- DRAIN->DONE when the final sum is accumulated.
- DONE->IDLE on result_ready.
REQ-020 in_ready SHALL equal (state==LOAD); a beat is accepted when in_valid and in_ready are both high on a rising edge.
REQ-021 Lane product with conjugation: re = ar*br + ai*bi, im = ai*br - ar*bi.
REQ-022 Lane product without conjugation: re = ar*br - ai*bi, im = ai*br + ar*bi.
REQ-023 Each component SHALL be truncated to its low ELEMENT_WIDTH/2 bits; all sums wrap modulo 2^(ELEMENT_WIDTH/2).
REQ-024 Products SHALL pass through a registered adder tree of clog2(NI) levels, then a registered accumulator.
REQ-025 The engine SHALL accept one beat per cycle with no bubbles, and gaps in in_valid SHALL be tolerated.
REQ-026 result_valid SHALL rise exactly MULT_LAT+clog2(NI)+1 cycles after the edge accepting the final beat.
REQ-027 result and result_valid SHALL hold stable in DONE until result_ready is high on an edge; result_valid SHALL fall on that edge.
REQ-028 start SHALL be ignored outside IDLE, including on the DONE->IDLE edge.
REQ-029 in_valid SHALL be ignored outside LOAD.
REQ-030 conj_mode SHALL be sampled with start and held for the whole operation.

Reset
REQ-031 Reset values: state IDLE; in_ready, result_valid and busy all 0; result 0; accumulator 0.
REQ-032 Reset SHALL clear all pipeline valid flags.
REQ-033 Reset asserted mid-operation SHALL abandon the operation with no stale contribution to any later result.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-035 Macro CDOT_CONJ_SELECT_EN controls mode selection.
REQ-036 With CDOT_CONJ_SELECT_EN defined, the conj_mode port SHALL exist and select the mode per operation.
REQ-037 Without CDOT_CONJ_SELECT_EN, the port SHALL be absent and the engine SHALL always compute a*conj(b).

Verification
Bench parameters for all scenarios: ELEMENT_WIDTH=64, NI=4, MULT_LAT=2, giving a latency of 5.
REQ-038 NOE=8, all a=(1+2j), all b=(3+4j), conjugate mode, 2 back-to-back beats -> result 88+16j, result_valid 5 cycles after beat 2.
REQ-039 Same data with conj_mode=0 (macro defined) -> result -40+80j.
REQ-040 NOE=6, final beat lanes 2-3 driven with 0x7FFF... garbage -> result 66+12j.
REQ-041 result_ready low for 10 cycles in DONE, start pulsed meanwhile -> result stable and busy=1; one cycle after result_ready, state is IDLE and no new operation has started.
REQ-042 Reset one cycle after beat 1 is accepted, then a full NOE=8 operation with the REQ-038 data -> result exactly 88+16j.
REQ-043 in_valid toggled 1,0,0,1 during LOAD -> result identical to the REQ-038 case; in_valid high in IDLE is never accepted.
